// File: rtl/dz_seq_ctrl.sv
// Countdown sequencer for the dot-matrix display: debounced start/pause keys drive
// num from START_NUM down to 1, hold the final symbol, then blank.
module dz_seq_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned DB_CYCLES = 20,
  parameter int unsigned START_NUM = 4,
  parameter int unsigned DONE_HOLD = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_start_i,
  input  logic       key_pause_i,
  output logic [2:0] num_o,
  output logic       running_o,
  output logic       done_o
);

  localparam int unsigned TickW    = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [7:0] DbLast   = 8'(DB_CYCLES - 1);
  localparam logic [7:0] HoldLast = 8'(DONE_HOLD - 1);
  localparam logic [2:0] StartNum = 3'(START_NUM);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  // Bit 0 is the start key, bit 1 the pause key.
  logic [1:0]      key_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      level_q, level_d;
  logic [1:0]      press_q, press_d;
  logic [1:0][7:0] db_cnt_q, db_cnt_d;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d, tick_inc;
  logic [7:0]       hold_q, hold_d;
  logic [2:0]       num_q, num_d;
  logic             tick_wrap, start_p, pause_p;

  assign key_raw = {key_pause_i, key_start_i};
  assign start_p = press_q[0];
  assign pause_p = press_q[1];

  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    press_d  = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DbLast) begin
          level_d[k]  = sync2_q[k];
          db_cnt_d[k] = '0;
          press_d[k]  = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 8'd1;
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign tick_wrap = (tick_q == TickLast);
  assign tick_inc  = tick_wrap ? '0 : tick_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    num_d   = num_q;
    if (start_p) begin
      // Start restarts from any state and wins over pause and a coincident step.
      state_d = StRun;
      num_d   = StartNum;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (pause_p) begin
            state_d = StPause;
          end else begin
            tick_d = tick_inc;
            if (tick_wrap) begin
              if (num_q > 3'd1) begin
                num_d = num_q - 3'd1;
              end else begin
                state_d = StDone;
                hold_d  = '0;
              end
            end
          end
        end
        StPause: begin
          if (pause_p) state_d = StRun;
        end
        StDone: begin
          tick_d = tick_inc;
          if (tick_wrap) begin
            if (hold_q == HoldLast) begin
              state_d = StIdle;
              num_d   = '0;
              tick_d  = '0;
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      tick_q  <= '0;
      hold_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      num_q   <= num_d;
    end
  end

  assign num_o     = num_q;
  assign running_o = (state_q == StRun);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_dz_seq_ctrl.sv
// Bench for dz_seq_ctrl: a time-based model (elapsed run/done cycles, run-length
// debounce) is compared every cycle, plus directed scenario checks at fixed offsets.
module tb_dz_seq_ctrl;

  localparam int TickDiv  = 10;
  localparam int DbCycles = 4;
  localparam int StartNum = 4;
  localparam int DoneHold = 3;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MDone  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start = 1'b0;
  logic       key_pause = 1'b0;
  logic [2:0] num;
  logic       running, done;
  logic       chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dz_seq_ctrl #(
    .TICK_DIV (TickDiv),
    .DB_CYCLES(DbCycles),
    .START_NUM(StartNum),
    .DONE_HOLD(DoneHold)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .key_start_i(key_start),
    .key_pause_i(key_pause),
    .num_o      (num),
    .running_o  (running),
    .done_o     (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Key model: a press is a synchronized level that has stayed at a new value for
  // DbCycles samples; the synchronized value lags the raw key by two samples.
  typedef struct {
    int s1;
    int s2;
    int run_val;
    int run_len;
    int level;
    int press;
  } key_m_t;

  key_m_t mk_q[2];
  int     m_mode, m_el, m_del;

  function automatic key_m_t key_step(key_m_t k, int raw);
    key_m_t n = k;
    int seen = k.s2;
    n.s2 = k.s1;
    n.s1 = raw;
    if (seen == k.run_val) n.run_len = k.run_len + 1;
    else begin
      n.run_val = seen;
      n.run_len = 1;
    end
    n.press = 0;
    if (seen != k.level && n.run_len >= DbCycles) begin
      n.level = seen;
      n.press = seen;
    end
    return n;
  endfunction

  // Sequencer model in terms of elapsed run cycles and elapsed done cycles.
  always @(posedge clk or posedge rst) begin : mdl
    int mode, el, del;
    if (rst) begin
      for (int i = 0; i < 2; i++) mk_q[i] <= '{default: 0};
      m_mode <= MIdle;
      m_el   <= 0;
      m_del  <= 0;
    end else begin
      mode = m_mode;
      el   = m_el;
      del  = m_del;
      if (mk_q[0].press != 0) begin
        mode = MRun;
        el   = 0;
      end else if (mode == MRun) begin
        if (mk_q[1].press != 0) mode = MPause;
        else begin
          el++;
          if (el == StartNum * TickDiv) begin
            mode = MDone;
            del  = 0;
          end
        end
      end else if (mode == MPause) begin
        if (mk_q[1].press != 0) mode = MRun;
      end else if (mode == MDone) begin
        del++;
        if (del == DoneHold * TickDiv) mode = MIdle;
      end
      m_mode <= mode;
      m_el   <= el;
      m_del  <= del;
      mk_q[0] <= key_step(mk_q[0], int'(key_start));
      mk_q[1] <= key_step(mk_q[1], int'(key_pause));
    end
  end

  function automatic int exp_num();
    if (m_mode == MIdle) return 0;
    if (m_mode == MDone) return 1;
    return StartNum - m_el / TickDiv;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_num", int'(num), exp_num());
      check("model_running", int'(running), int'(m_mode == MRun));
      check("model_done", int'(done), int'(m_mode == MDone));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k, n_rise, first;
    logic prev;
    #2 rst = 1'b1;
    #1;
    check("reset_num", int'(num), 0);
    check("reset_running", int'(running), 0);
    check("reset_done", int'(done), 0);
    cyc(2);
    rst    = 1'b0;
    chk_en = 1'b1;

    cyc(50);
    check("idle_num", int'(num), 0);
    check("idle_running", int'(running), 0);

    // Full countdown from a 20-cycle start press.
    key_start = 1'b1;
    k = 0;
    while (!running && k < 20) begin
      cyc(1);
      k++;
    end
    check("start_latency_edges", k - 1, 6);
    check("run_first_num", int'(num), 4);
    cyc(9);
    check("num4_last_cycle", int'(num), 4);
    cyc(1);
    check("num3_first_cycle", int'(num), 3);
    cyc(3);
    key_start = 1'b0;
    cyc(17);
    check("num1_running", int'(num), 1);
    check("num1_running_flag", int'(running), 1);
    cyc(10);
    check("done_entry_num", int'(num), 1);
    check("done_entry_flag", int'(done), 1);
    check("done_entry_running", int'(running), 0);
    cyc(29);
    check("done_last_cycle", int'(done), 1);
    cyc(1);
    check("blank_num", int'(num), 0);
    check("blank_done", int'(done), 0);

    // Bouncing key never settles long enough to register.
    for (int i = 0; i < 30; i++) begin
      key_start = (i % 2 == 0);
      cyc(1);
    end
    key_start = 1'b0;
    cyc(20);
    check("bounce_running", int'(running), 0);
    check("bounce_num", int'(num), 0);

    // Pause at num=3, tick=6; resume and count the remaining 4 cycles.
    key_start = 1'b1;
    k = 0;
    while (!running && k < 20) begin
      cyc(1);
      k++;
    end
    cyc(2);
    key_start = 1'b0;
    cyc(8);
    key_pause = 1'b1;
    cyc(7);
    check("pause_running", int'(running), 0);
    check("pause_num", int'(num), 3);
    cyc(1);
    key_pause = 1'b0;
    for (int i = 0; i < 99; i++) begin
      cyc(1);
      check("pause_hold_num", int'(num), 3);
    end
    key_pause = 1'b1;
    cyc(7);
    check("resume_running", int'(running), 1);
    cyc(3);
    check("resume_num3", int'(num), 3);
    cyc(1);
    check("resume_num2", int'(num), 2);
    key_pause = 1'b0;

    // Start and pause together during RUN: restart, no pause.
    cyc(2);
    key_start = 1'b1;
    key_pause = 1'b1;
    cyc(7);
    check("both_restart_num", int'(num), 4);
    check("both_restart_running", int'(running), 1);
    cyc(1);
    key_start = 1'b0;
    key_pause = 1'b0;
    cyc(5);
    check("both_no_pause", int'(running), 1);

    // DONE ignores pause, honours start.
    k = 0;
    while (!done && k < 100) begin
      cyc(1);
      k++;
    end
    check("reach_done", int'(done), 1);
    key_pause = 1'b1;
    cyc(8);
    key_pause = 1'b0;
    cyc(4);
    check("done_pause_ignored", int'(done), 1);
    check("done_pause_not_running", int'(running), 0);
    key_start = 1'b1;
    cyc(6);
    check("done_start_pending", int'(done), 1);
    cyc(1);
    check("done_start_running", int'(running), 1);
    check("done_start_num", int'(num), 4);
    key_start = 1'b0;

    // Asynchronous reset at num=2 with start held through release.
    k = 0;
    while (num != 3'd2 && k < 100) begin
      cyc(1);
      k++;
    end
    check("reach_num2", int'(num), 2);
    key_start = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_num", int'(num), 0);
    check("async_rst_running", int'(running), 0);
    check("async_rst_done", int'(done), 0);
    cyc(3);
    rst    = 1'b0;
    n_rise = 0;
    first  = 0;
    prev   = running;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (running && !prev) begin
        n_rise++;
        if (first == 0) first = i;
      end
      prev = running;
    end
    check("rst_held_key_one_restart", n_rise, 1);
    check("rst_restart_edge", first, DbCycles + 3);
    key_start = 1'b0;
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
